// File: rtl/sat_counter_table.sv
// sat_counter_table
//   Table of DEPTH saturating counters (WIDTH bits each) for the branch
//   predictor. After reset or Flush the table clears itself by writing
//   INIT_VALUE to one entry per cycle; Ready is low until that finishes.
//
//   Optional feature macro: SAT_COUNTER_TABLE_STATS_EN
//     adds MispredCount, a saturating 32-bit count of RUN updates whose
//     outcome disagreed with the pre-update prediction (entry MSB).
//
// Ports
//   Clk          rising-edge clock
//   Rst_n        synchronous active-low reset
//   Flush        restart the init sequence (drops a same-cycle update)
//   Ready        table initialised, lookups/updates accepted
//   LookupValid  lookup request
//   LookupIndex  entry to read
//   PredValid    registered lookup result valid (one cycle after request)
//   PredTaken    MSB of PredCounter
//   PredCounter  returned counter value, holds while PredValid is low
//   UpdValid     train request
//   UpdIndex     entry to train
//   UpdTaken     resolved outcome, 1 = taken
//   MispredCount (stats build only) misprediction counter

module sat_counter_table #(
  parameter  int WIDTH      = 2,
  parameter  int DEPTH      = 64,
  parameter  int INIT_VALUE = 1,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  output logic             Ready,
  input  logic             LookupValid,
  input  logic [IDX_W-1:0] LookupIndex,
  output logic             PredValid,
  output logic             PredTaken,
  output logic [WIDTH-1:0] PredCounter,
  input  logic             UpdValid,
  input  logic [IDX_W-1:0] UpdIndex,
  input  logic             UpdTaken
`ifdef SAT_COUNTER_TABLE_STATS_EN
  ,
  output logic [31:0]      MispredCount
`endif
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] INIT_CNT = WIDTH'(INIT_VALUE);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [WIDTH-1:0] counterTable [DEPTH];
  logic [0:0]       state;
  logic [IDX_W-1:0] initPtr;

  logic             isRun;
  logic             lookupAccept;
  logic             updAccept;
  logic             bypassHit;
  logic [WIDTH-1:0] updCurrent;
  logic [WIDTH-1:0] updNext;
  logic [WIDTH-1:0] lookupData;

  assign isRun        = (state == RUN);
  assign Ready        = isRun;
  assign lookupAccept = isRun && LookupValid;
  // A flush in the same cycle wins over training.
  assign updAccept    = isRun && UpdValid && !Flush;
  assign bypassHit    = updAccept && (LookupIndex == UpdIndex);

  // Saturating next value of the entry being trained.
  always_comb begin
    // NOTE: default first so every path assigns updNext; otherwise a latch is inferred.
    updCurrent = counterTable[UpdIndex];
    updNext    = updCurrent;
    if (UpdTaken) begin
      if (updCurrent != CNT_MAX) updNext = updCurrent + CNT_ONE;
    end else begin
      if (updCurrent != '0) updNext = updCurrent - CNT_ONE;
    end
  end

  // Same-index lookup sees the value being written this cycle.
  assign lookupData = bypassHit ? updNext : counterTable[LookupIndex];

  // Init/run sequencing. Init ends on the cycle that writes entry DEPTH-1.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!Rst_n) begin
      state   <= INIT;
      initPtr <= '0;
    end else if (Flush) begin
      state   <= INIT;
      initPtr <= '0;
    end else if (state == INIT) begin
      initPtr <= initPtr + IDX_ONE;
      if (&initPtr) state <= RUN;
    end
  end

  // Counter storage.
  always_ff @(posedge Clk) begin
    // NOTE: the array has no reset; the INIT sequence is its only clear, which keeps it RAM-mappable.
    if (Rst_n) begin
      if (!isRun) begin
        counterTable[initPtr] <= INIT_CNT;
      end else if (updAccept) begin
        counterTable[UpdIndex] <= updNext;
      end
    end
  end

  // Registered lookup result.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      PredValid   <= 1'b0;
      PredCounter <= '0;
    end else begin
      PredValid <= lookupAccept;
      if (lookupAccept) PredCounter <= lookupData;
    end
  end

  assign PredTaken = PredCounter[WIDTH-1];

`ifdef SAT_COUNTER_TABLE_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n || Flush) begin
      MispredCount <= '0;
    end else if (updAccept && (updCurrent[WIDTH-1] != UpdTaken) && (MispredCount != '1)) begin
      MispredCount <= MispredCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_counter_table.sv
module tb_sat_counter_table;

  localparam int W  = 2;
  localparam int D  = 16;
  localparam int IV = 1;
  localparam int MAXV = (1 << W) - 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WIDTH=2, DEPTH=16, INIT_VALUE=1)
  logic       rstN = 1'b0, flush = 1'b0, lv = 1'b0, uv = 1'b0, ut = 1'b0;
  logic [3:0] li = '0, ui = '0;
  logic       ready, pv, pt;
  logic [1:0] pc;
  logic [31:0] mc;

  // Second DUT (WIDTH=3, DEPTH=16, INIT_VALUE=3)
  logic       rst3 = 1'b0, flush3 = 1'b0, lv3 = 1'b0, uv3 = 1'b0, ut3 = 1'b0;
  logic [3:0] li3 = '0, ui3 = '0;
  logic       ready3, pv3, pt3;
  logic [2:0] pc3;
  logic [31:0] mc3;

  sat_counter_table #(.WIDTH(W), .DEPTH(D), .INIT_VALUE(IV)) dut (
    .Clk(clk), .Rst_n(rstN), .Flush(flush), .Ready(ready),
    .LookupValid(lv), .LookupIndex(li),
    .PredValid(pv), .PredTaken(pt), .PredCounter(pc),
    .UpdValid(uv), .UpdIndex(ui), .UpdTaken(ut)
`ifdef SAT_COUNTER_TABLE_STATS_EN
    , .MispredCount(mc)
`endif
  );

  sat_counter_table #(.WIDTH(3), .DEPTH(16), .INIT_VALUE(3)) dut3 (
    .Clk(clk), .Rst_n(rst3), .Flush(flush3), .Ready(ready3),
    .LookupValid(lv3), .LookupIndex(li3),
    .PredValid(pv3), .PredTaken(pt3), .PredCounter(pc3),
    .UpdValid(uv3), .UpdIndex(ui3), .UpdTaken(ut3)
`ifdef SAT_COUNTER_TABLE_STATS_EN
    , .MispredCount(mc3)
`endif
  );

`ifndef SAT_COUNTER_TABLE_STATS_EN
  assign mc  = '0;
  assign mc3 = '0;
`endif

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the table as a plain array, init as a countdown.
  typedef struct { int cyc; int val; } exp_t;
  exp_t q[$];
  int   model[D];
  int   initLeft = D;
  int   misModel = 0;
  bit   modelValid = 0;
  bit   monitorOn = 0;
  int   cycle = 0;

  always @(posedge clk) cycle++;

  function automatic int satNext(int v, bit taken, int maxv);
    if (taken) return (v < maxv) ? v + 1 : v;
    return (v > 0) ? v - 1 : v;
  endfunction

  // One clock cycle of stimulus; the model is advanced as the edge would.
  task automatic step(bit r, bit f, bit l, int lidx, bit u, int uidx, bit t);
    bit rdy;
    @(negedge clk); #1;
    rstN = r; flush = f; lv = l; li = lidx[3:0]; uv = u; ui = uidx[3:0]; ut = t;
    if (modelValid) begin
      check("ready", {31'd0, ready}, {31'd0, initLeft == 0});
`ifdef SAT_COUNTER_TABLE_STATS_EN
      check("mispred_count", mc, misModel);
`endif
    end
    if (!r) begin
      initLeft = D;
      misModel = 0;
      foreach (model[i]) model[i] = IV;
      modelValid = 1;
    end else begin
      rdy = (initLeft == 0);
      if (rdy && l) begin
        exp_t e;
        e.cyc = cycle + 1;
        e.val = (u && !f && lidx == uidx) ? satNext(model[uidx], t, MAXV) : model[lidx];
        q.push_back(e);
      end
      if (f) begin
        initLeft = D;
        misModel = 0;
        foreach (model[i]) model[i] = IV;
      end else if (!rdy) begin
        initLeft--;
      end else if (u) begin
        if (((model[uidx] >> (W - 1)) & 1) != int'(t)) misModel++;
        model[uidx] = satNext(model[uidx], t, MAXV);
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every PredValid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (monitorOn && pv === 1'b1) begin
      if (q.size() == 0) begin
        check("pred_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pred_cycle", cycle, e.cyc);
        check("pred_counter", {30'd0, pc}, e.val);
        check("pred_taken", {31'd0, pt}, (e.val >> (W - 1)) & 1);
      end
    end
  end

  initial begin
    int n;

    // ---- WIDTH=3 instance, INIT_VALUE=3 (main DUT held in reset) ----
    repeat (2) begin @(negedge clk); #1; end
    rst3 = 1'b1;
    n = 0;
    while (ready3 !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    check("w3_init_cycles", n, 16);
    uv3 = 1'b1; ut3 = 1'b1; ui3 = 4'd0;
    @(negedge clk); #1;
    uv3 = 1'b0; lv3 = 1'b1; li3 = 4'd0;
    @(negedge clk); #1;
    lv3 = 1'b0;
    check("w3_pred_valid", {31'd0, pv3}, 1);
    check("w3_pred_counter", {29'd0, pc3}, 4);
    check("w3_pred_taken", {31'd0, pt3}, 1);
`ifdef SAT_COUNTER_TABLE_STATS_EN
    check("w3_mispred", mc3, 1);
`endif

    // ---- Main instance ----
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    monitorOn = 1;
    @(negedge clk); #1;
    check("rst_pred_valid", {31'd0, pv}, 0);
    check("rst_pred_counter", {30'd0, pc}, 0);
    check("rst_pred_taken", {31'd0, pt}, 0);
    check("rst_ready", {31'd0, ready}, 0);

    // Init takes 16 cycles (Ready checked every step), then lookup idx 5.
    idle(17);
    step(1, 0, 1, 5, 0, 0, 0);
    idle(1);

    // Saturate up, then down, on idx 3.
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0, 1, 3, 1); step(1, 0, 1, 3, 0, 0, 0); end
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0, 1, 3, 0); step(1, 0, 1, 3, 0, 0, 0); end

    // Same-cycle bypass and non-interacting indices.
    step(1, 0, 1, 7, 1, 7, 1);
    step(1, 0, 1, 8, 1, 7, 1);
    idle(1);

    // Train idx 2 to 3, flush, updates during INIT, second flush at init cycle 10.
    step(1, 0, 0, 0, 1, 2, 1);
    step(1, 0, 0, 0, 1, 2, 1);
    step(1, 0, 1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 1, 2, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 1, i, 1, i, i % 2);
    step(1, 1, 0, 0, 1, 4, 1);
    for (int i = 0; i < 17; i++) step(1, 0, 1, i % 16, 1, i % 16, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 1, i, 0, 0, 0);
    idle(1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      int lidx, uidx;
      lidx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, D - 1);
      uidx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, D - 1);
      step(1, $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, lidx,
           $urandom_range(0, 9) < 6, uidx, $urandom_range(0, 1) == 1);
    end

    idle(3);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
